branch_recovery_ctrl: RTL and testbench

Sequencer sitting beside the EX-stage branch decision logic. It accepts each resolved branch/jump, and on a misprediction runs a redirect-and-squash sequence: registered PC redirect, pipeline flush pulses, then a squash window that ignores resolves from wrong-path instructions. Every accepted resolve is queued as a training record for the branch predictor/BTB through a valid/ready port. It also keeps saturating performance counters.

---
 rtl/branch_pkg.sv | 18 +
 rtl/upd_fifo.sv | 56 +++++
 rtl/branch_recovery_ctrl.sv | 130 +++++++++++++
 tb/tb_branch_recovery_ctrl.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types for the branch recovery sequencer and its predictor-update FIFO.
package branch_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } rc_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] target;
    logic        taken;
  } upd_rec_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/upd_fifo.sv
// Synchronous FIFO of predictor training records; head is zeroed while empty
// so the update port reads all-zero after reset.
module upd_fifo
  import branch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  upd_rec_t push_data,
  input  logic     pop,
  output upd_rec_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  upd_rec_t          r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == (AW+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign w_pop_ok  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = push && (!full || w_pop_ok);
  assign head      = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/branch_recovery_ctrl.sv
// Redirect/flush/squash sequencer for EX-resolved branches, with a training
// record queue toward the predictor and saturating performance counters.
module branch_recovery_ctrl
  import branch_pkg::*;
#(
  parameter int SQUASH_CYCLES = 2,
  parameter int UPD_DEPTH     = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             resolve_valid,
  input  logic             mispredict,
  input  logic             decision,
  input  logic [31:0]      resolve_pc,
  input  logic [31:0]      target_pc,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             squashing,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [31:0]      upd_pc,
  output logic [31:0]      upd_target,
  output logic             upd_taken,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count,
  output logic [CNT_W-1:0] drop_count
);

  rc_state_t        r_state;
  logic [3:0]       r_sq_cnt;
  logic             r_redirect;
  logic             r_squashing;
  logic [31:0]      r_redirect_pc;
  logic [CNT_W-1:0] r_branch_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_accept;
  logic             w_pop;
  logic             w_drop;
  logic             w_full;
  logic             w_empty;
  upd_rec_t         w_push_rec;
  upd_rec_t         w_head;

  assign w_accept   = resolve_valid && (r_state == IDLE);
  assign w_pop      = !w_empty && upd_ready;
  assign w_drop     = w_accept && w_full && !w_pop;
  assign w_push_rec = '{pc: resolve_pc, target: target_pc, taken: decision};

  upd_fifo #(.DEPTH(UPD_DEPTH)) u_upd_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_accept),
    .push_data (w_push_rec),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_sq_cnt      <= '0;
      r_redirect    <= 1'b0;
      r_squashing   <= 1'b0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept && mispredict) begin
            r_state       <= REDIRECT;
            r_redirect    <= 1'b1;
            r_redirect_pc <= decision ? target_pc : resolve_pc + PC_INC;
          end
        end
        REDIRECT: begin
          r_state     <= SQUASH;
          r_redirect  <= 1'b0;
          r_squashing <= 1'b1;
          r_sq_cnt    <= 4'(SQUASH_CYCLES);
        end
        SQUASH: begin
          // Counter value 1 marks the last squashed cycle.
          if (r_sq_cnt == 4'd1) begin
            r_state     <= IDLE;
            r_squashing <= 1'b0;
          end else begin
            r_sq_cnt <= r_sq_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_redirect  <= 1'b0;
          r_squashing <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_branch_cnt  <= '0;
      r_mispred_cnt <= '0;
      r_drop_cnt    <= '0;
    end else begin
      if (w_accept && !(&r_branch_cnt))               r_branch_cnt  <= r_branch_cnt + 1'b1;
      if (w_accept && mispredict && !(&r_mispred_cnt)) r_mispred_cnt <= r_mispred_cnt + 1'b1;
      if (w_drop && !(&r_drop_cnt))                   r_drop_cnt    <= r_drop_cnt + 1'b1;
    end
  end

  assign redirect_valid   = r_redirect;
  assign flush_ifid       = r_redirect;
  assign flush_idex       = r_redirect;
  assign redirect_pc      = r_redirect_pc;
  assign squashing        = r_squashing;
  assign upd_valid        = !w_empty;
  assign upd_pc           = w_head.pc;
  assign upd_target       = w_head.target;
  assign upd_taken        = w_head.taken;
  assign branch_count     = r_branch_cnt;
  assign mispredict_count = r_mispred_cnt;
  assign drop_count       = r_drop_cnt;

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Bench for branch_recovery_ctrl: directed vector table, saturation sequence,
// and randomized traffic against a cycle-indexed reference model.
module tb_branch_recovery_ctrl;
  import branch_pkg::*;

  localparam int S = 2;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        resolve_valid = 1'b0, mispredict = 1'b0, decision = 1'b0;
  logic [31:0] resolve_pc = '0, target_pc = '0;
  logic        upd_ready = 1'b0;

  logic        redirect_valid, flush_ifid, flush_idex, squashing, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [15:0] branch_count, mispredict_count, drop_count;

  logic        s_redirect_valid, s_flush_ifid, s_flush_idex, s_squashing, s_upd_valid, s_upd_taken;
  logic [31:0] s_redirect_pc, s_upd_pc, s_upd_target;
  logic [3:0]  s_branch_count, s_mispredict_count, s_drop_count;

  always #5 clk = ~clk;

  branch_recovery_ctrl #(.SQUASH_CYCLES(S), .UPD_DEPTH(D), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .resolve_valid(resolve_valid), .mispredict(mispredict),
    .decision(decision), .resolve_pc(resolve_pc), .target_pc(target_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex), .squashing(squashing),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
    .upd_target(upd_target), .upd_taken(upd_taken), .branch_count(branch_count),
    .mispredict_count(mispredict_count), .drop_count(drop_count)
  );

  branch_recovery_ctrl #(.SQUASH_CYCLES(S), .UPD_DEPTH(D), .CNT_W(4)) u_dut_sat (
    .clk(clk), .rst(rst), .resolve_valid(resolve_valid), .mispredict(mispredict),
    .decision(decision), .resolve_pc(resolve_pc), .target_pc(target_pc),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc),
    .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex), .squashing(s_squashing),
    .upd_valid(s_upd_valid), .upd_ready(upd_ready), .upd_pc(s_upd_pc),
    .upd_target(s_upd_target), .upd_taken(s_upd_taken), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count), .drop_count(s_drop_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: cycle index of the last accepted mispredict decides
  // redirect/squash windows; the queue models the update FIFO.
  int          cyc = 0;
  int          mp_cyc = -1000;
  logic [31:0] m_rpc = '0;
  upd_rec_t    m_q[$];
  int          m_bc = 0, m_mc = 0, m_dc = 0;

  function automatic logic [63:0] sat(input int v, input int w);
    int mx = (1 << w) - 1;
    return (v > mx) ? 64'(mx) : 64'(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic mp, input logic dec,
                      input logic [31:0] pc, input logic [31:0] tgt, input logic rdy);
    logic     pop, acc, e_redir, e_sq;
    upd_rec_t h;
    @(negedge clk);
    rst = r; resolve_valid = rv; mispredict = mp; decision = dec;
    resolve_pc = pc; target_pc = tgt; upd_ready = rdy;
    if (r) begin
      m_q.delete(); m_bc = 0; m_mc = 0; m_dc = 0; mp_cyc = -1000; m_rpc = '0;
    end else begin
      pop = (m_q.size() > 0) && rdy;
      acc = rv && (cyc >= mp_cyc + 2 + S);
      if (pop) void'(m_q.pop_front());
      if (acc) begin
        m_bc++;
        if (mp) begin
          m_mc++;
          mp_cyc = cyc;
          m_rpc = dec ? tgt : pc + 32'd4;
        end
        if (m_q.size() < D) m_q.push_back('{pc: pc, target: tgt, taken: dec});
        else m_dc++;
      end
    end
    @(posedge clk);
    #1;
    e_redir = (cyc == mp_cyc);
    e_sq    = (cyc >= mp_cyc + 1) && (cyc <= mp_cyc + S);
    h = (m_q.size() > 0) ? m_q[0] : '0;
    chk("redirect_valid", 64'(redirect_valid), 64'(e_redir));
    chk("flush_ifid", 64'(flush_ifid), 64'(e_redir));
    chk("flush_idex", 64'(flush_idex), 64'(e_redir));
    chk("redirect_pc", 64'(redirect_pc), 64'(m_rpc));
    chk("squashing", 64'(squashing), 64'(e_sq));
    chk("upd_valid", 64'(upd_valid), 64'(m_q.size() > 0));
    chk("upd_pc", 64'(upd_pc), 64'(h.pc));
    chk("upd_target", 64'(upd_target), 64'(h.target));
    chk("upd_taken", 64'(upd_taken), 64'(h.taken));
    chk("branch_count", 64'(branch_count), sat(m_bc, 16));
    chk("mispredict_count", 64'(mispredict_count), sat(m_mc, 16));
    chk("drop_count", 64'(drop_count), sat(m_dc, 16));
    chk("sat_branch_count", 64'(s_branch_count), sat(m_bc, 4));
    chk("sat_mispredict_count", 64'(s_mispredict_count), sat(m_mc, 4));
    chk("sat_drop_count", 64'(s_drop_count), sat(m_dc, 4));
    $display("cyc=%0d rst=%0b rv=%0b mp=%0b pc=%h rdy=%0b | redir=%0b rpc=%h sq=%0b uv=%0b upc=%h bc=%0d mc=%0d dc=%0d",
             cyc, r, rv, mp, pc, rdy, redirect_valid, redirect_pc, squashing, upd_valid, upd_pc,
             branch_count, mispredict_count, drop_count);
    cyc++;
  endtask

  typedef struct {
    logic rst, rv, mp, dec;
    logic [31:0] pc, tgt;
    logic rdy;
    logic e_redir;
    logic [31:0] e_rpc;
    logic e_sq, e_uv;
    logic [31:0] e_upc;
    int e_bc, e_mc, e_dc;
  } vec_t;

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        0, 0, 0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      32'h200,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100,      1, 0, 0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h400,      32'h800,  1'b0, 1'b1, 32'h404, 1'b0, 1'b1, 32'h100,      2, 1, 0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h500,      32'h0,    1'b0, 1'b0, 32'h404, 1'b1, 1'b1, 32'h100,      2, 1, 0};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h600,      32'h0,    1'b0, 1'b0, 32'h404, 1'b1, 1'b1, 32'h100,      2, 1, 0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h700,      32'h0,    1'b0, 1'b0, 32'h404, 1'b0, 1'b1, 32'h100,      2, 1, 0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h800,      32'h900,  1'b0, 1'b0, 32'h404, 1'b0, 1'b1, 32'h100,      3, 1, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b1, 1'b0, 32'h404, 1'b0, 1'b1, 32'h400,      3, 1, 1};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'hA00,      32'hB00,  1'b0, 1'b0, 32'h404, 1'b0, 1'b1, 32'h400,      4, 1, 1};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hC00,      32'hD00,  1'b1, 1'b0, 32'h404, 1'b0, 1'b1, 32'hA00,      5, 1, 1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b1, 1'b0, 32'h404, 1'b0, 1'b1, 32'hC00,      5, 1, 1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b1, 1'b0, 32'h404, 1'b0, 1'b0, 32'h0,        5, 1, 1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFFFFFC, 32'h1234, 1'b1, 1'b1, 32'h0,   1'b0, 1'b1, 32'hFFFFFFFC, 6, 2, 1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b1, 1'b0, 32'h0,   1'b1, 1'b0, 32'h0,        6, 2, 1};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        32'h0,    1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 32'h0,        0, 0, 0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h100,      32'h200,  1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 32'h100,      1, 0, 0};

    for (int i = 0; i < 16; i++) begin
      step(vecs[i].rst, vecs[i].rv, vecs[i].mp, vecs[i].dec, vecs[i].pc, vecs[i].tgt, vecs[i].rdy);
      chk($sformatf("vec%0d_redirect_valid", i), 64'(redirect_valid), 64'(vecs[i].e_redir));
      chk($sformatf("vec%0d_redirect_pc", i), 64'(redirect_pc), 64'(vecs[i].e_rpc));
      chk($sformatf("vec%0d_squashing", i), 64'(squashing), 64'(vecs[i].e_sq));
      chk($sformatf("vec%0d_upd_valid", i), 64'(upd_valid), 64'(vecs[i].e_uv));
      chk($sformatf("vec%0d_upd_pc", i), 64'(upd_pc), 64'(vecs[i].e_upc));
      chk($sformatf("vec%0d_branch_count", i), 64'(branch_count), 64'(vecs[i].e_bc));
      chk($sformatf("vec%0d_mispredict_count", i), 64'(mispredict_count), 64'(vecs[i].e_mc));
      chk($sformatf("vec%0d_drop_count", i), 64'(drop_count), 64'(vecs[i].e_dc));
    end

    // Back-to-back mispredicts: one is accepted every S+2 cycles.
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
    for (int i = 0; i < 20 * (S + 2); i++)
      step(1'b0, 1'b1, 1'b1, 1'b1, 32'h1000 + 32'(i), 32'h2000, 1'b1);
    chk("sat4_mispredict_count", 64'(s_mispredict_count), 64'd15);
    chk("cnt16_mispredict_count", 64'(mispredict_count), 64'd20);

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pc;
      pc = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0),
           1'($urandom), pc, $urandom, (i % 400 < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
